// File: rtl/wb_write_queue_pkg.sv
// ---------------------------------------------------------------------------
// wb_write_queue_pkg
//   Shared definitions for the writeback write queue: datapath widths, the
//   register indices that receive the two halves of a MUL result, the default
//   queue depth and the {dest, data} entry type.
// ---------------------------------------------------------------------------
package wb_write_queue_pkg;

    localparam int WORD_LEN          = 32;
    localparam int REG_FILE_ADDR_LEN = 5;
    localparam int LO_REG_IDX        = 13;
    localparam int HI_REG_IDX        = 12;
    localparam int WBQ_DEPTH         = 4;

    typedef struct packed {
        logic [REG_FILE_ADDR_LEN-1:0] dest;
        logic [WORD_LEN-1:0]          data;
    } wbq_entry_t;

endpackage

// File: rtl/wb_write_queue_lookup.sv
// ---------------------------------------------------------------------------
// wbq_lookup
//   Youngest-match search over the pending entries of the write queue.
//   The entry arrays are presented in age order: index 0 is the oldest
//   (the head), higher indices are younger. Later matches override earlier
//   ones, so the result is the youngest pending value for the address.
//
// Ports:
//   dest  in  DEPTH x ADDR_LEN  entry destinations, age ordered
//   data  in  DEPTH x WORD_LEN  entry data, age ordered
//   vld   in  DEPTH             entry is pending
//   src   in  ADDR_LEN          lookup address (r0 never hits)
//   hit   out 1                 a pending entry matched
//   value out WORD_LEN          youngest matching data, zero when no hit
// ---------------------------------------------------------------------------
module wbq_lookup
    import wb_write_queue_pkg::*;
#(
    parameter int WORD_LEN = wb_write_queue_pkg::WORD_LEN,
    parameter int ADDR_LEN = REG_FILE_ADDR_LEN,
    parameter int DEPTH    = WBQ_DEPTH
) (
    input  logic [DEPTH-1:0][ADDR_LEN-1:0] dest,
    input  logic [DEPTH-1:0][WORD_LEN-1:0] data,
    input  logic [DEPTH-1:0]               vld,
    input  logic [ADDR_LEN-1:0]            src,
    output logic                           hit,
    output logic [WORD_LEN-1:0]            value
);

    always_comb begin
        hit   = 1'b0;
        value = '0;
        if (src != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && (dest[i] == src)) begin
                    hit   = 1'b1;
                    value = data[i];
                end
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// ---------------------------------------------------------------------------
// wb_write_queue
//   Collects retiring writeback results and serialises them onto the single
//   register file write port. A MUL result is expanded into two entries
//   (LO word first, then HI word). Pending entries are searchable by two
//   bypass lookup ports so decode sees values not yet written.
//
//   Optional build macro WBQ_COALESCE_EN: a non-MUL push whose destination
//   matches a pending non-head entry overwrites that entry's data in place
//   instead of allocating a new slot. Undefined: every write allocates.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   wb_valid/wb_ready    writeback handshake (ready needs two free slots)
//   wb_dest, wb_data     non-MUL destination and result (LO word for MUL)
//   wb_is_mul, wb_hi     MUL pair flag and high word
//   rf_stall             register file cannot take a write this cycle
//   rf_we/rf_dest/rf_data register file write port, driven from the head
//   lk_src1/2            bypass lookup addresses
//   lk_hit1/2, lk_data1/2 bypass result (youngest pending match)
//   occupancy            number of pending entries including the head
// ---------------------------------------------------------------------------
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int WORD_LEN = wb_write_queue_pkg::WORD_LEN,
    parameter int ADDR_LEN = REG_FILE_ADDR_LEN,
    parameter int DEPTH    = WBQ_DEPTH,
    parameter int LO_REG   = LO_REG_IDX,
    parameter int HI_REG   = HI_REG_IDX
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [ADDR_LEN-1:0]     wb_dest,
    input  logic [WORD_LEN-1:0]     wb_data,
    input  logic                    wb_is_mul,
    input  logic [WORD_LEN-1:0]     wb_hi,

    input  logic                    rf_stall,
    output logic                    rf_we,
    output logic [ADDR_LEN-1:0]     rf_dest,
    output logic [WORD_LEN-1:0]     rf_data,

    input  logic [ADDR_LEN-1:0]     lk_src1,
    input  logic [ADDR_LEN-1:0]     lk_src2,
    output logic                    lk_hit1,
    output logic                    lk_hit2,
    output logic [WORD_LEN-1:0]     lk_data1,
    output logic [WORD_LEN-1:0]     lk_data2,

    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage: data only, never reset; validity comes from rptr/count.
    logic [ADDR_LEN-1:0] dest_mem [DEPTH];
    logic [WORD_LEN-1:0] data_mem [DEPTH];

    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [PW-1:0] wptr_p1;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] free_slots;

    logic          accept;
    logic          acc_mul;
    logic          acc_one;
    logic          acc_coal;
    logic          pop;
    logic [1:0]    push_n;

    logic          co_hit;
    logic [PW-1:0] co_idx;

    // Age-ordered view of the queue, index 0 = head.
    logic [DEPTH-1:0][ADDR_LEN-1:0] ord_dest;
    logic [DEPTH-1:0][WORD_LEN-1:0] ord_data;
    logic [DEPTH-1:0]               ord_vld;

    // Ready depends only on registered count, so a pop in a full cycle
    // does not reopen the queue until the following cycle.
    assign free_slots = CW'(DEPTH) - count;
    assign wb_ready   = !rst && (free_slots >= CW'(2));
    assign accept     = wb_valid && wb_ready;

    assign acc_mul  = accept && wb_is_mul;
    assign acc_coal = accept && !wb_is_mul && (wb_dest != '0) && co_hit;
    assign acc_one  = accept && !wb_is_mul && (wb_dest != '0) && !co_hit;
    assign push_n   = acc_mul ? 2'd2 : (acc_one ? 2'd1 : 2'd0);

    assign rf_we   = !rst && (count != '0) && !rf_stall;
    assign pop     = rf_we;
    assign rf_dest = dest_mem[rptr];
    assign rf_data = data_mem[rptr];

    assign occupancy  = rst ? '0 : count;
    assign count_next = count + CW'(push_n) - CW'(pop);
    assign wptr_p1    = wptr + PW'(1);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ord_dest[i] = dest_mem[rptr + PW'(i)];
            ord_data[i] = data_mem[rptr + PW'(i)];
            ord_vld[i]  = !rst && (CW'(i) < count);
        end
    end

`ifdef WBQ_COALESCE_EN
    // Search younger-than-head entries only: the head may be written to the
    // register file this very cycle, so it must not be modified.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (ord_vld[i] && (ord_dest[i] == wb_dest)) begin
                co_hit = 1'b1;
                co_idx = rptr + PW'(i);
            end
        end
    end
`else
    assign co_hit = 1'b0;
    assign co_idx = '0;
`endif

    // Control state: pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            rptr  <= rptr + PW'(pop);
            wptr  <= wptr + PW'(push_n);
            count <= count_next;
        end
    end

    // Entry storage writes; accept already excludes reset via wb_ready.
    always_ff @(posedge clk) begin
        if (acc_mul) begin
            dest_mem[wptr]    <= ADDR_LEN'(LO_REG);
            data_mem[wptr]    <= wb_data;
            dest_mem[wptr_p1] <= ADDR_LEN'(HI_REG);
            data_mem[wptr_p1] <= wb_hi;
        end else if (acc_one) begin
            dest_mem[wptr]    <= wb_dest;
            data_mem[wptr]    <= wb_data;
        end else if (acc_coal) begin
            data_mem[co_idx]  <= wb_data;
        end
    end

    wbq_lookup #(
        .WORD_LEN (WORD_LEN),
        .ADDR_LEN (ADDR_LEN),
        .DEPTH    (DEPTH)
    ) u_lookup1 (
        .dest  (ord_dest),
        .data  (ord_data),
        .vld   (ord_vld),
        .src   (lk_src1),
        .hit   (lk_hit1),
        .value (lk_data1)
    );

    wbq_lookup #(
        .WORD_LEN (WORD_LEN),
        .ADDR_LEN (ADDR_LEN),
        .DEPTH    (DEPTH)
    ) u_lookup2 (
        .dest  (ord_dest),
        .data  (ord_data),
        .vld   (ord_vld),
        .src   (lk_src2),
        .hit   (lk_hit2),
        .value (lk_data2)
    );

endmodule

// File: tb/tb_wb_write_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_write_queue
//   Drives directed and random writeback traffic into wb_write_queue. The
//   reference model is a queue of pending {dest, data} writes; writes the
//   model expects to reach the register file are handed to a scoreboard
//   that a separate monitor consumes whenever the DUT asserts rf_we.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_write_queue;
    import wb_write_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = REG_FILE_ADDR_LEN;
    localparam int DW    = WORD_LEN;

    logic           clk = 1'b0;
    logic           rst;
    logic           wb_valid;
    logic           wb_ready;
    logic [AW-1:0]  wb_dest;
    logic [DW-1:0]  wb_data;
    logic           wb_is_mul;
    logic [DW-1:0]  wb_hi;
    logic           rf_stall;
    logic           rf_we;
    logic [AW-1:0]  rf_dest;
    logic [DW-1:0]  rf_data;
    logic [AW-1:0]  lk_src1;
    logic [AW-1:0]  lk_src2;
    logic           lk_hit1;
    logic           lk_hit2;
    logic [DW-1:0]  lk_data1;
    logic [DW-1:0]  lk_data2;
    logic [$clog2(DEPTH):0] occupancy;

    always #5 clk = ~clk;

    wb_write_queue #(
        .WORD_LEN (DW),
        .ADDR_LEN (AW),
        .DEPTH    (DEPTH),
        .LO_REG   (LO_REG_IDX),
        .HI_REG   (HI_REG_IDX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_dest   (wb_dest),
        .wb_data   (wb_data),
        .wb_is_mul (wb_is_mul),
        .wb_hi     (wb_hi),
        .rf_stall  (rf_stall),
        .rf_we     (rf_we),
        .rf_dest   (rf_dest),
        .rf_data   (rf_data),
        .lk_src1   (lk_src1),
        .lk_src2   (lk_src2),
        .lk_hit1   (lk_hit1),
        .lk_hit2   (lk_hit2),
        .lk_data1  (lk_data1),
        .lk_data2  (lk_data2),
        .occupancy (occupancy)
    );

    int checks = 0;
    int errors = 0;

    wbq_entry_t pending[$];  // accepted, not yet written (oldest first)
    wbq_entry_t exp_q[$];    // writes expected on the port this cycle

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_lookup(input logic [AW-1:0] src, output logic hit,
                                         output logic [DW-1:0] val);
        hit = 1'b0;
        val = '0;
        if (src != '0) begin
            foreach (pending[i]) begin
                if (pending[i].dest == src) begin
                    hit = 1'b1;
                    val = pending[i].data;
                end
            end
        end
    endfunction

    // One clock cycle: drive inputs, compare state-visible outputs with the
    // model, then advance the model by what happens at the next edge.
    task automatic cycle(input logic v, input logic [AW-1:0] d, input logic [DW-1:0] dat,
                         input logic m, input logic [DW-1:0] hi, input logic st,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic r);
        logic          exp_ready;
        logic          h;
        logic [DW-1:0] val;
        int            cj;
        wbq_entry_t    e;
        @(negedge clk);
        rst       = r;
        wb_valid  = v;
        wb_dest   = d;
        wb_data   = dat;
        wb_is_mul = m;
        wb_hi     = hi;
        rf_stall  = st;
        lk_src1   = s1;
        lk_src2   = s2;
        #1;
        if (r) pending.delete();
        exp_ready = !r && ((DEPTH - pending.size()) >= 2);
        check("wb_ready", 64'(wb_ready), 64'(exp_ready));
        check("occupancy", 64'(occupancy), 64'(pending.size()));
        model_lookup(s1, h, val);
        check("lk_hit1", 64'(lk_hit1), 64'(h));
        check("lk_data1", 64'(lk_data1), 64'(val));
        model_lookup(s2, h, val);
        check("lk_hit2", 64'(lk_hit2), 64'(h));
        check("lk_data2", 64'(lk_data2), 64'(val));
        if (pending.size() != 0) begin
            check("head_dest", 64'(rf_dest), 64'(pending[0].dest));
            check("head_data", 64'(rf_data), 64'(pending[0].data));
        end

        cj = -1;
`ifdef WBQ_COALESCE_EN
        if (v && exp_ready && !m && (d != '0)) begin
            for (int i = 1; i < pending.size(); i++)
                if (pending[i].dest == d) cj = i;
        end
`endif
        if (cj >= 0) begin
            e = pending[cj];
            e.data = dat;
            pending[cj] = e;
        end
        if (!r && (pending.size() != 0) && !st) exp_q.push_back(pending.pop_front());
        if (v && exp_ready && (cj < 0)) begin
            if (m) begin
                e.dest = AW'(LO_REG_IDX); e.data = dat; pending.push_back(e);
                e.dest = AW'(HI_REG_IDX); e.data = hi;  pending.push_back(e);
            end else if (d != '0) begin
                e.dest = d; e.data = dat; pending.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, st, '0, '0, 1'b0);
    endtask

    task automatic push(input logic [AW-1:0] d, input logic [DW-1:0] dat, input logic st);
        cycle(1'b1, d, dat, 1'b0, '0, st, d, '0, 1'b0);
    endtask

    // Monitor: consumes the scoreboard whenever the DUT writes.
    initial begin : monitor
        wbq_entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got dest %0d data 0x%0h, expected no write (t=%0t)",
                             rf_dest, rf_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_dest", 64'(rf_dest), 64'(e.dest));
                    check("wr_data", 64'(rf_data), 64'(e.data));
                end
            end else if (rf_we !== 1'b0) begin
                check("rf_we_known", 64'(rf_we), 64'(0));
            end
            check("missed_write", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
    end

    initial begin : stimulus
        rst = 1'b1; wb_valid = 1'b0; wb_dest = '0; wb_data = '0; wb_is_mul = 1'b0;
        wb_hi = '0; rf_stall = 1'b0; lk_src1 = '0; lk_src2 = '0;

        cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, AW'(5), '0, 1'b1);

        // Basic latency
        push(AW'(5), 32'hDEADBEEF, 1'b0);
        idle(3, 1'b0);

        // MUL expansion
        cycle(1'b1, AW'(3), 32'h11, 1'b1, 32'h22, 1'b0, AW'(13), AW'(12), 1'b0);
        idle(4, 1'b0);

        // r0 drop
        push(AW'(0), 32'd7, 1'b0);
        idle(3, 1'b0);

        // Backpressure: third push fills to 3, then ready stays low
        push(AW'(1), 32'hA1, 1'b1);
        push(AW'(2), 32'hA2, 1'b1);
        push(AW'(3), 32'hA3, 1'b1);
        push(AW'(4), 32'hA4, 1'b1);
        push(AW'(4), 32'hA4, 1'b1);
        idle(5, 1'b0);

        // Bypass: r7 twice while stalled, then r8 / r7 to exercise younger hits
        push(AW'(7), 32'd1, 1'b1);
        push(AW'(7), 32'd2, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, AW'(7), AW'(0), 1'b0);
        idle(3, 1'b0);
        push(AW'(7), 32'd3, 1'b1);
        push(AW'(8), 32'd4, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, AW'(8), AW'(7), 1'b0);
        idle(1, 1'b1);
        push(AW'(8), 32'd5, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, AW'(8), AW'(7), 1'b0);
        idle(4, 1'b0);

        // Reset mid-drain with three pending entries
        push(AW'(9),  32'hB1, 1'b1);
        push(AW'(10), 32'hB2, 1'b1);
        push(AW'(11), 32'hB3, 1'b1);
        cycle(1'b1, AW'(6), 32'hB4, 1'b0, '0, 1'b0, AW'(9), AW'(10), 1'b1);
        idle(4, 1'b0);

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 99) < 60,
                  AW'($urandom_range(0, 15)),
                  DW'($urandom),
                  $urandom_range(0, 9) == 0,
                  DW'($urandom),
                  $urandom_range(0, 99) < 35,
                  AW'($urandom_range(0, 15)),
                  AW'($urandom_range(0, 15)),
                  $urandom_range(0, 299) == 0);
        end

        idle(8, 1'b0);
        check("final_pending", 64'(pending.size()), 64'(0));
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
